// File: rtl/wb_scheduler.sv
// wb_scheduler: round-robin write-back arbiter for the shared register-file
// write port, plus a 64-entry pending-write scoreboard (0-31 int, 32-63 fp)
// that decode uses to stall RAW/WAW hazards.
// Optional build macro: WB_SCHED_FWD_EN adds rs1/rs2 forwarding outputs that
// expose the write-cycle data and release rsX_busy one cycle earlier.
module wb_scheduler #(
    parameter int unsigned NREQ   = 3,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [7*NREQ-1:0]        req_rd,
    input  logic [DATA_W*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic [6:0]               wb_rd,
    output logic [DATA_W-1:0]        rddata,
    output logic                     we,
    input  logic                     issue_valid,
    input  logic [6:0]               issue_rd,
    output logic                     issue_ready,
    input  logic [5:0]               rs1,
    input  logic [5:0]               rs2,
    output logic                     rs1_busy,
`ifdef WB_SCHED_FWD_EN
    output logic                     rs1_fwd,
    output logic [DATA_W-1:0]        rs1_fwd_data,
    output logic                     rs2_fwd,
    output logic [DATA_W-1:0]        rs2_fwd_data,
`endif
    output logic                     rs2_busy
);

    localparam int unsigned RD_W  = 7;
    localparam int unsigned NREGS = 64;
    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW    = IDX_W + 1;

    logic [RD_W-1:0]   rd_arr   [NREQ];
    logic [DATA_W-1:0] data_arr [NREQ];

    logic [IDX_W-1:0]  last_grant;
    logic [IDX_W-1:0]  grant_idx;
    logic              grant_any;
    logic [NREQ-1:0]   grant_vec;
    logic [CW-1:0]     cand;
    logic [IDX_W-1:0]  cand_idx;

    logic [NREGS-1:0]  busy;
    logic              sb_set;
    logic              sb_clr;
    logic              fwd1;
    logic              fwd2;

    // Split the flat requester buses into per-requester views.
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign rd_arr[i]   = req_rd[i*RD_W +: RD_W];
        assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        grant_vec = '0;
        cand      = '0;
        cand_idx  = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            cand = {1'b0, last_grant} + CW'(k + 1);
            if (cand >= CW'(NREQ)) begin
                cand = cand - CW'(NREQ);
            end
            cand_idx = cand[IDX_W-1:0];
            if (!grant_any && req_valid[cand_idx]) begin
                grant_any = 1'b1;
                grant_idx = cand_idx;
            end
        end
        grant_vec[grant_idx] = grant_any;
    end

    // No grant is offered while reset is asserted.
    assign req_ready = rst ? grant_vec : '0;

    // Write-port output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            we         <= 1'b0;
            wb_rd      <= '0;
            rddata     <= '0;
            last_grant <= IDX_W'(NREQ - 1);
        end else begin
            we <= grant_any;
            if (grant_any) begin
                wb_rd      <= rd_arr[grant_idx];
                rddata     <= data_arr[grant_idx];
                last_grant <= grant_idx;
            end
        end
    end

    // Hardwired-zero registers (0 and 32) are never tracked as pending.
    assign issue_ready = ~busy[issue_rd[5:0]] | ~issue_rd[6];
    assign sb_set      = issue_valid & issue_ready & issue_rd[6] & (|issue_rd[4:0]);
    assign sb_clr      = we & wb_rd[6];

    // Scoreboard update; the set is applied last so it wins a same-index clash.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            if (sb_clr) begin
                busy[wb_rd[5:0]] <= 1'b0;
            end
            if (sb_set) begin
                busy[issue_rd[5:0]] <= 1'b1;
            end
        end
    end

`ifdef WB_SCHED_FWD_EN
    // Expose the committing write to decode so it need not wait a cycle.
    assign fwd1         = we & wb_rd[6] & (wb_rd[5:0] == rs1) & (|rs1[4:0]);
    assign fwd2         = we & wb_rd[6] & (wb_rd[5:0] == rs2) & (|rs2[4:0]);
    assign rs1_fwd      = fwd1;
    assign rs2_fwd      = fwd2;
    assign rs1_fwd_data = rddata;
    assign rs2_fwd_data = rddata;
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    assign rs1_busy = busy[rs1] & (|rs1[4:0]) & ~fwd1;
    assign rs2_busy = busy[rs2] & (|rs2[4:0]) & ~fwd2;

endmodule

// File: tb/tb_wb_scheduler.sv
// tb_wb_scheduler: directed scenarios followed by randomized traffic for
// wb_scheduler. A behavioural model predicts grants, write-port contents and
// scoreboard state; predicted writes are queued and a monitor checks them
// whenever the DUT strobes we. Honours WB_SCHED_FWD_EN if defined.
module tb_wb_scheduler;

    localparam int NREQ = 3;
    localparam int DW   = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [7*NREQ-1:0]    req_rd;
    logic [DW*NREQ-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic [6:0]           wb_rd;
    logic [DW-1:0]        rddata;
    logic                 we;
    logic                 issue_valid;
    logic [6:0]           issue_rd;
    logic                 issue_ready;
    logic [5:0]           rs1;
    logic [5:0]           rs2;
    logic                 rs1_busy;
    logic                 rs2_busy;
`ifdef WB_SCHED_FWD_EN
    logic                 rs1_fwd;
    logic [DW-1:0]        rs1_fwd_data;
    logic                 rs2_fwd;
    logic [DW-1:0]        rs2_fwd_data;
`endif

    always #5 clk = ~clk;

    wb_scheduler #(.NREQ(NREQ), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_rd       (req_rd),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .wb_rd        (wb_rd),
        .rddata       (rddata),
        .we           (we),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_ready  (issue_ready),
        .rs1          (rs1),
        .rs2          (rs2),
        .rs1_busy     (rs1_busy),
`ifdef WB_SCHED_FWD_EN
        .rs1_fwd      (rs1_fwd),
        .rs1_fwd_data (rs1_fwd_data),
        .rs2_fwd      (rs2_fwd),
        .rs2_fwd_data (rs2_fwd_data),
`endif
        .rs2_busy     (rs2_busy)
    );

    typedef struct packed {
        logic [6:0]    rd;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    // Reference model state: pending-register set, write-port contents, last grant.
    bit          m_busy [64];
    bit          m_we;
    logic [6:0]  m_wbrd;
    logic [DW-1:0] m_wbdata;
    int          m_ptr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pick();
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (m_ptr + k) % NREQ;
            if (req_valid[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [5:0] rreg();
        return {1'($urandom_range(0, 1)), 2'b00, 3'($urandom_range(0, 7))};
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 64; r++) m_busy[r] = 1'b0;
        m_we     = 1'b0;
        m_wbrd   = '0;
        m_wbdata = '0;
        m_ptr    = NREQ - 1;
    endtask

    // One clock: check outputs mid-cycle, predict the next state, advance.
    task automatic step(input bit keep);
        int   g;
        bit   e_ir, f1, f2, e_b1, e_b2;
        bit   n_busy [64];
        bit   n_we;
        logic [6:0] n_wbrd;
        logic [DW-1:0] n_wbdata;
        int   n_ptr;

        @(negedge clk);
        g = rst ? pick() : -1;
        check("req_ready", 64'(req_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
        check("we", 64'(we), 64'(m_we));
        check("wb_rd", 64'(wb_rd), 64'(m_wbrd));
        check("rddata", 64'(rddata), 64'(m_wbdata));
        e_ir = !(issue_rd[6] && m_busy[issue_rd[5:0]]);
        check("issue_ready", 64'(issue_ready), 64'(e_ir));
        f1 = 1'b0;
        f2 = 1'b0;
`ifdef WB_SCHED_FWD_EN
        f1 = m_we && m_wbrd[6] && (m_wbrd[5:0] == rs1) && (rs1[4:0] != 0);
        f2 = m_we && m_wbrd[6] && (m_wbrd[5:0] == rs2) && (rs2[4:0] != 0);
        check("rs1_fwd", 64'(rs1_fwd), 64'(f1));
        check("rs2_fwd", 64'(rs2_fwd), 64'(f2));
        if (f1) check("rs1_fwd_data", 64'(rs1_fwd_data), 64'(m_wbdata));
        if (f2) check("rs2_fwd_data", 64'(rs2_fwd_data), 64'(m_wbdata));
`endif
        e_b1 = m_busy[rs1] && (rs1[4:0] != 0) && !f1;
        e_b2 = m_busy[rs2] && (rs2[4:0] != 0) && !f2;
        check("rs1_busy", 64'(rs1_busy), 64'(e_b1));
        check("rs2_busy", 64'(rs2_busy), 64'(e_b2));

        if (g >= 0) exp_q.push_back({req_rd[g*7 +: 7], req_data[g*DW +: DW]});

        n_busy   = m_busy;
        n_we     = m_we;
        n_wbrd   = m_wbrd;
        n_wbdata = m_wbdata;
        n_ptr    = m_ptr;
        if (!rst) begin
            for (int r = 0; r < 64; r++) n_busy[r] = 1'b0;
            n_we = 1'b0; n_wbrd = '0; n_wbdata = '0; n_ptr = NREQ - 1;
        end else begin
            n_we = (g >= 0);
            if (g >= 0) begin
                n_wbrd   = req_rd[g*7 +: 7];
                n_wbdata = req_data[g*DW +: DW];
                n_ptr    = g;
            end
            if (m_we && m_wbrd[6]) n_busy[m_wbrd[5:0]] = 1'b0;
            if (issue_valid && e_ir && issue_rd[6] && issue_rd[4:0] != 0)
                n_busy[issue_rd[5:0]] = 1'b1;
        end

        @(posedge clk);
        #1;
        m_busy = n_busy; m_we = n_we; m_wbrd = n_wbrd; m_wbdata = n_wbdata; m_ptr = n_ptr;
        if (g >= 0 && !keep) req_valid[g] = 1'b0;
    endtask

    task automatic post(input int i, input logic [6:0] rd, input logic [DW-1:0] d);
        req_valid[i]        = 1'b1;
        req_rd[i*7 +: 7]    = rd;
        req_data[i*DW +: DW] = d;
    endtask

    // Monitor: every write strobe must match the oldest predicted grant.
    initial begin : monitor
        wr_t e;
        forever begin
            @(negedge clk);
            if (we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL wb_unexpected: got write rd=%0h data=%0h, expected none", wb_rd, rddata);
                end else begin
                    e = exp_q.pop_front();
                    check("wb_q_rd", 64'(wb_rd), 64'(e.rd));
                    check("wb_q_data", 64'(rddata), 64'(e.data));
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        rst = 1'b0; req_valid = '0; req_rd = '0; req_data = '0;
        issue_valid = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset held with every requester valid.
        req_valid = '1;
        for (int c = 0; c < 3; c++) begin
            rs1 = 6'($urandom);
            step(1'b1);
        end
        rst = 1'b1;

        // Round robin with continuous requests.
        post(0, 7'h01, 32'h11);
        post(1, 7'h02, 32'h22);
        post(2, 7'h03, 32'h33);
        for (int c = 0; c < 6; c++) step(1'b1);
        req_valid = '0;
        step(1'b0);

        // RAW on reg 5.
        issue_valid = 1'b1; issue_rd = {1'b1, 6'd5};
        step(1'b0);
        issue_valid = 1'b0; rs1 = 6'd5;
        step(1'b0);
        post(1, {1'b1, 6'd5}, 32'hDEADBEEF);
        step(1'b0);
        step(1'b0);
        step(1'b0);

        // WAW stall on reg 40, then set/clear collision on the same edge.
        issue_valid = 1'b1; issue_rd = {1'b1, 6'd40};
        step(1'b0);
        step(1'b0);
        issue_valid = 1'b0;
        post(2, {1'b1, 6'd40}, 32'hA5A5_0040);
        step(1'b0);
        step(1'b0);
        post(0, {1'b1, 6'd40}, 32'h0000_4040);
        step(1'b0);
        issue_valid = 1'b1; issue_rd = {1'b1, 6'd40};
        step(1'b0);
        issue_valid = 1'b0; rs2 = 6'd40;
        step(1'b0);
        step(1'b0);

        // Zero registers and writes with enable cleared.
        issue_valid = 1'b1; issue_rd = {1'b1, 6'd32}; rs2 = 6'd32;
        step(1'b0);
        issue_valid = 1'b0; rs1 = 6'd32;
        step(1'b0);
        issue_valid = 1'b1; issue_rd = {1'b1, 6'd7};
        step(1'b0);
        issue_valid = 1'b0;
        post(0, {1'b0, 6'd7}, 32'h7777_7777);
        step(1'b0);
        rs1 = 6'd7;
        step(1'b0);
        step(1'b0);

        // Reset arriving while a write is in flight.
        issue_valid = 1'b1; issue_rd = {1'b1, 6'd9};
        post(1, {1'b1, 6'd9}, 32'h0909_0909);
        step(1'b0);
        issue_valid = 1'b0; rst = 1'b0; rs1 = 6'd9;
        post(2, {1'b1, 6'd9}, 32'h1234_5678);
        step(1'b0);
        rst = 1'b1;
        req_valid = '0;
        step(1'b0);
        step(1'b0);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 149) != 0);
            issue_valid = ($urandom_range(0, 1) != 0);
            issue_rd = {($urandom_range(0, 3) != 0), rreg()};
            rs1 = rreg();
            rs2 = rreg();
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) != 0)
                    post(i, {($urandom_range(0, 3) != 0), rreg()}, $urandom);
            end
            step(1'b0);
        end

        // Drain outstanding writes.
        rst = 1'b1; req_valid = '0; issue_valid = 1'b0;
        for (int c = 0; c < 3; c++) step(1'b0);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_scheduler.md
Name: wb_scheduler

Overview:
- Shares the single register-file write port (wb_rd/rddata/we) among NREQ write-back producers (e.g. ALU, load unit, FPU) using round-robin arbitration and registered outputs.
- Holds a 64-entry scoreboard (0-31 integer, 32-63 float) of pending writes, so decode can stall RAW/WAW hazards on rs1/rs2/rd.
- Sits between the execution units and the 64x32 register file; its outputs drive the register file's write port directly.

Parameters:
- NREQ, 3, number of write-back requesters (2..8); index 0 has round-robin priority after reset.
- DATA_W, 32, write data width.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  NREQ  requester i has a result.
- req_rd  in  7*NREQ  slice i = {enable, reg[5:0]}.
- req_data  in  DATA_W*NREQ  slice i = result.
- req_ready  out  NREQ  one-hot grant; handshake completes when valid & ready.
- wb_rd  out  7  to register file {enable, reg}.
- rddata  out  DATA_W  to register file.
- we  out  1  to register file write strobe.
- issue_valid  in  1  decode issues an instruction that writes issue_rd.
- issue_rd  in  7  {enable, reg} of the issuing instruction.
- issue_ready  out  1  0 means the destination is already pending (WAW stall).
- rs1, rs2  in  6  source registers being decoded.
- rs1_busy, rs2_busy  out  1  the source has a pending write (RAW stall).

Behaviour:
- Reset (rst=0 at posedge): we=0, wb_rd=0, rddata=0, all 64 busy bits cleared, RR pointer set so that index 0 is searched first. req_ready is 0 in reset cycles. Reset mid-operation drops in-flight grants; no write is issued after reset.
- Arbitration (combinational): search starts at (last_grant+1) mod NREQ; the first req_valid index found gets req_ready=1. At most one ready per cycle. last_grant updates only on a grant.
- req_ready depends only on req_valid and the pointer, never on data. Requesters hold valid/rd/data stable until ready.
- Output register, 1-cycle latency: a grant in cycle N gives we=1, wb_rd=req_rd[i], rddata=req_data[i] in cycle N+1. With no grant, we=0 and wb_rd/rddata hold their previous values.
- A granted request with rd[6]=0 still consumes the slot. It produces we=1 with wb_rd[6]=0, so the register file ignores it, and it does not touch the scoreboard.
- Scoreboard set: at posedge, if issue_valid & issue_ready & issue_rd[6] & issue_rd[4:0]!=0, then busy[issue_rd[5:0]] <= 1.
- Scoreboard clear: at posedge, if we & wb_rd[6], then busy[wb_rd[5:0]] <= 0. This is the same edge at which the register file writes.
- Set and clear of the same index at the same edge: set wins.
- issue_ready = ~busy[issue_rd[5:0]] | ~issue_rd[6]. It is combinational and ignores a clear happening in the same cycle.
- rsX_busy = busy[rsX] & (rsX[4:0]!=0). Registers 0 and 32 are never busy, matching their hardwired-zero reads.
- No queueing: back-pressure is carried by req_ready only. A starved requester waits at most NREQ-1 grants.

Optional Feature:
- Macro: WB_SCHED_FWD_EN.
- Defined: adds outputs rs1_fwd (1), rs1_fwd_data (DATA_W), rs2_fwd (1), rs2_fwd_data (DATA_W).
  - rsX_fwd = we & wb_rd[6] & wb_rd[5:0]==rsX & rsX[4:0]!=0, and rsX_fwd_data = rddata.
  - rsX_busy is forced to 0 whenever rsX_fwd=1, so decode proceeds one cycle earlier.
- Undefined: these ports are absent, and rsX_busy stays 1 through the write cycle.

Test Plan:
- Reset: hold rst=0 for 3 cycles while all req_valid=1 -> req_ready=0, we=0, rs1_busy=0 for every rs1. After release, first grant goes to index 0.
- Round robin: NREQ=3, all req_valid=1 continuously -> grants 0,1,2,0,1,2. Data 0x11/0x22/0x33 appears on rddata one cycle after each grant.
- Scoreboard RAW: issue rd={1,6'd5}, then rs1=5 -> rs1_busy=1. Requester 1 writes reg 5 with 0xDEADBEEF -> we=1 next cycle, and rs1_busy=0 the cycle after. With WB_SCHED_FWD_EN, rs1_busy=0 and rs1_fwd_data=0xDEADBEEF during the we cycle.
- WAW and set/clear collision: busy[40]=1 -> issue_ready=0 for issue_rd={1,6'd40}. When the write of reg 40 commits and a new issue to reg 40 lands on the same edge -> busy[40] remains 1.
- Zero registers: issue_rd={1,6'd32}, rs2=32 -> rs2_busy=0 and the busy bit is never set. A write with rd={0,6'd7} -> busy[7] unchanged.
- Reset mid-operation: grant issued, then rst=0 before the output cycle -> we=0, and the scoreboard is cleared the following cycle.
